striping_ctrl: RTL and testbench
================================

# striping_ctrl

Scheduler and sequencer in front of the `demux_striping` byte/word striper in the PCIe physical-layer path, running in the `clk_2f` domain. After link enable it emits a fixed training sequence on every active lane, then feeds buffered payload words to the striper one per cycle. It drives the lane select so words alternate lane 0 / lane 1 in x2 mode and stay on lane 0 in x1 mode. A small FIFO with a valid/ready handshake decouples the upstream producer.

## Interface
- `DATA_W`, 32, payload word width
- `FIFO_DEPTH`, 4, payload buffer entries (power of two, ≥2)
- `TS_COUNT`, 4, training words per active lane
- `TS_WORD`, 32'hBCBCBCBC, training word
- `IDLE_WORD`, 32'h7C7C7C7C, value of `out_data` when no word is issued

- `clk_2f`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `link_en`  in  1  level; 1 = bring up and run link, 0 = return to IDLE
- `cfg_x2`  in  1  lane mode, sampled only on IDLE→TRAIN (1 = two lanes, 0 = lane 0 only)
- `in_valid`  in  1  upstream word valid
- `in_data`  in  DATA_W  upstream word
- `in_ready`  out  1  FIFO can accept (combinational: state≠IDLE and not full)
- `out_valid`  out  1  registered; word on `out_data` is issued this cycle (maps to striper `valid_in`)
- `out_data`  out  DATA_W  registered word to striper `data_input`
- `out_sel`  out  1  registered target lane for the current word (0 = lane 0, 1 = lane 1)
- `state_o`  out  2  current state (IDLE=0, TRAIN=1, DATA=2)
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  occupancy

## Operation
- Reset: state IDLE; `out_valid`=0, `out_data`=IDLE_WORD, `out_sel`=0, `fifo_count`=0, `in_ready`=0, training counter 0, latched mode 0.
- IDLE: no issue, no accept. On `link_en`=1, latch `cfg_x2` into `mode_x2`, clear training counter, go to TRAIN.
- TRAIN: issue TS_WORD every cycle (`out_valid`=1). Total training words = TS_COUNT×(mode_x2 ? 2 : 1). After the last one, go to DATA. FIFO accepts during TRAIN.
- DATA: if the FIFO is non-empty, pop the head into `out_data` with `out_valid`=1. Otherwise `out_valid`=0 and `out_data`=IDLE_WORD.
- Lane select: after every issued word (training or payload), `out_sel` toggles when mode_x2=1 and is held at 0 when mode_x2=0. Because the training count is even in x2, the first payload word always targets lane 0.
- `link_en`=0 in TRAIN or DATA: next edge goes to IDLE, flushes the FIFO (count=0), sets `out_sel`=0 and `out_valid`=0. Words presented that cycle are dropped; `in_ready` is already 0 in IDLE.
- `cfg_x2` changes outside the IDLE→TRAIN edge are ignored.
- FIFO: push on `in_valid`&&`in_ready`; pop when DATA and non-empty. Simultaneous push and pop leaves the count unchanged. When full, `in_ready`=0 even if a pop occurs the same cycle. Read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Word accepted at edge N into an empty FIFO while in DATA: popped at edge N+1, so `out_valid`=1 with that word after edge N+1. This is one cycle of latency.
- IDLE→TRAIN takes one edge after `link_en` rises. The first TS_WORD is visible after the following edge.
- x1: TRAIN lasts 4 cycles. x2: TRAIN lasts 8 cycles. The DATA state is entered on the edge that issues the last TS_WORD.
- Asynchronous `reset` mid-operation forces all reset values immediately, independent of `clk_2f`.

## Structure
- Shared package `pcs_pkg`: state encoding (IDLE/TRAIN/DATA), TS_WORD and IDLE_WORD constants, lane-select encoding.
- One sub-module: `sync_fifo` (parameterised DATA_W/FIFO_DEPTH, push/pop/full/empty/count).
- The FSM, training counter and lane toggle live in `striping_ctrl`.

## Test plan
- Reset then `link_en`=1, `cfg_x2`=1: expect 8 TS_WORDs with `out_sel` 0,1,0,1,0,1,0,1, then `state_o`=2, `out_valid`=0, `out_data`=32'h7C7C7C7C.
- x2 payload: push AAAAAAAA, EEEEEEEE, CCCCCCCC, 11111111 back-to-back in DATA. Expect them issued in order on consecutive cycles with `out_sel` 0,1,0,1 and one-cycle latency.
- x1 mode (`cfg_x2`=0): 4 TS_WORDs, then payload 99999999, FFFFFFFF both with `out_sel`=0. Toggle `cfg_x2` mid-DATA: no effect.
- Backpressure: push 6 words during TRAIN (x2). Expect `in_ready`=0 once `fifo_count`=4. In DATA, all 4 accepted words are issued in order and pushes resume as the count drops.
- Drop `link_en` with `fifo_count`=3: next edge `state_o`=0, `fifo_count`=0, `out_valid`=0, `out_sel`=0. Re-enable: training restarts from count 0.
- Assert `reset` asynchronously mid-TRAIN (x2, after 3 TS words): outputs reach reset values before the next `clk_2f` edge. After release, a full training sequence is issued again.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared definitions for the PCIe PCS striping path: controller states, fixed
// symbol words and lane-select encoding.
package pcs_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrain = 2'd1,
    StData  = 2'd2
  } state_e;

  typedef enum logic {
    Lane0 = 1'b0,
    Lane1 = 1'b1
  } lane_e;

  localparam logic [31:0] TsWord   = 32'hBCBCBCBC;
  localparam logic [31:0] IdleWord = 32'h7C7C7C7C;

  // Lane for the word after the current one: alternate in x2, pinned to lane 0 in x1.
  function automatic logic lane_after(input logic cur, input logic x2);
    return x2 ? ~cur : Lane0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, synchronous flush and occupancy count.
// Pointers wrap naturally because FIFO_DEPTH is a power of two.
module sync_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk_2f,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              push,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              pop,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/striping_ctrl.sv
// Link bring-up sequencer and payload scheduler feeding the demux_striping lane striper:
// training burst on every active lane, then buffered payload one word per cycle.
module striping_ctrl
  import pcs_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter int unsigned        TS_COUNT   = 4,
  parameter logic [DATA_W-1:0]  TS_WORD    = DATA_W'(TsWord),
  parameter logic [DATA_W-1:0]  IDLE_WORD  = DATA_W'(IdleWord)
) (
  input  logic                              clk_2f,
  input  logic                              reset,
  input  logic                              link_en,
  input  logic                              cfg_x2,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_sel,
  output logic [1:0]                        state_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned TsCntW = $clog2(2 * TS_COUNT + 1);

  state_e            state_q;
  logic              mode_x2_q;
  logic [TsCntW-1:0] ts_cnt_q;
  logic              next_lane_q;
  logic              out_valid_q, out_sel_q;
  logic [DATA_W-1:0] out_data_q;

  logic              drop, pop, issue;
  logic [TsCntW-1:0] ts_last;
  logic [DATA_W-1:0] out_data_d;
  logic [DATA_W-1:0] fifo_rd;
  logic              fifo_full, fifo_empty;

  always_comb begin
    drop    = (state_q != StIdle) && !link_en;
    pop     = (state_q == StData) && link_en && !fifo_empty;
    issue   = !drop && ((state_q == StTrain) || pop);
    ts_last = mode_x2_q ? TsCntW'(2 * TS_COUNT - 1) : TsCntW'(TS_COUNT - 1);
    out_data_d = IDLE_WORD;
    if (!drop) begin
      if (state_q == StTrain) out_data_d = TS_WORD;
      else if (pop)           out_data_d = fifo_rd;
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_x2_q   <= 1'b0;
      ts_cnt_q    <= '0;
      next_lane_q <= Lane0;
      out_valid_q <= 1'b0;
      out_data_q  <= IDLE_WORD;
      out_sel_q   <= Lane0;
    end else begin
      out_valid_q <= issue;
      out_data_q  <= out_data_d;
      if (drop) begin
        state_q     <= StIdle;
        out_sel_q   <= Lane0;
        next_lane_q <= Lane0;
      end else begin
        if (issue) begin
          out_sel_q   <= next_lane_q;
          next_lane_q <= lane_after(next_lane_q, mode_x2_q);
        end
        unique case (state_q)
          StIdle: begin
            if (link_en) begin
              mode_x2_q   <= cfg_x2;
              ts_cnt_q    <= '0;
              next_lane_q <= Lane0;
              state_q     <= StTrain;
            end
          end
          StTrain: begin
            ts_cnt_q <= ts_cnt_q + TsCntW'(1);
            // Leave on the edge that issues the final training word.
            if (ts_cnt_q == ts_last) state_q <= StData;
          end
          StData:  state_q <= StData;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .flush   (drop),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready  = (state_q != StIdle) && !fifo_full;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_striping_ctrl.sv
// Self-checking bench for striping_ctrl: directed vector table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_striping_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TSN   = 4;
  localparam logic [31:0] TS    = 32'hBCBCBCBC;
  localparam logic [31:0] IDLE  = 32'h7C7C7C7C;

  logic        clk_2f = 1'b0;
  logic        reset, link_en, cfg_x2, in_valid, in_ready, out_valid, out_sel;
  logic [31:0] in_data, out_data;
  logic [1:0]  state_o;
  logic [2:0]  fifo_count;

  striping_ctrl #(
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH),
    .TS_COUNT   (TSN),
    .TS_WORD    (TS),
    .IDLE_WORD  (IDLE)
  ) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .link_en    (link_en),
    .cfg_x2     (cfg_x2),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .state_o    (state_o),
    .fifo_count (fifo_count)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: link phase, queue of buffered words, count of issued words.
  int          m_st;
  bit          m_mode;
  int          m_tcnt, m_issued;
  logic [31:0] m_q[$];
  logic        m_vld, m_sel, m_rdy;
  logic [31:0] m_dat;

  task automatic model_reset();
    m_st = 0; m_mode = 0; m_tcnt = 0; m_issued = 0; m_q.delete();
    m_vld = 0; m_sel = 0; m_dat = IDLE;
  endtask

  task automatic model_step(input logic l, input logic c, input logic v, input logic [31:0] d);
    bit acc;
    acc = v && m_rdy;
    if (m_st == 0) begin
      m_vld = 0; m_dat = IDLE;
      if (l) begin m_mode = c; m_tcnt = 0; m_issued = 0; m_st = 1; end
    end else if (!l) begin
      m_st = 0; m_q.delete(); m_vld = 0; m_dat = IDLE; m_sel = 0;
    end else begin
      if (m_st == 1) begin
        m_vld = 1; m_dat = TS;
        m_sel = m_mode ? (m_issued % 2 == 1) : 1'b0;
        m_issued++; m_tcnt++;
        if (m_tcnt == TSN * (m_mode ? 2 : 1)) m_st = 2;
      end else if (m_q.size() > 0) begin
        m_vld = 1; m_dat = m_q.pop_front();
        m_sel = m_mode ? (m_issued % 2 == 1) : 1'b0;
        m_issued++;
      end else begin
        m_vld = 0; m_dat = IDLE;
      end
      if (acc) m_q.push_back(d);
    end
  endtask

  task automatic compare_model();
    chk("out_valid", out_valid, m_vld);
    chk("out_data", out_data, m_dat);
    if (m_vld) chk("out_sel", out_sel, m_sel);
    chk("state_o", state_o, m_st);
    chk("fifo_count", fifo_count, m_q.size());
  endtask

  // One clock: drive at negedge, check in_ready before the edge, outputs at next negedge.
  task automatic cycle(input logic l, input logic c, input logic v, input logic [31:0] d,
                       output logic rdy_seen);
    link_en = l; cfg_x2 = c; in_valid = v; in_data = d;
    #1;
    m_rdy = (m_st != 0) && (m_q.size() < DEPTH);
    rdy_seen = in_ready;
    chk("in_ready", in_ready, m_rdy);
    @(posedge clk_2f);
    model_step(l, c, v, d);
    @(negedge clk_2f);
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, IDLE);
    chk({tag, "_sel"}, out_sel, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  // Asynchronous reset pulse raised between edges; values must settle before the next edge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk_2f);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        l, c, v;
    logic [31:0] din;
    logic        rdy, vld;
    logic [31:0] dout;
    logic        sel;
    logic [1:0]  st;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(input logic l, input logic c, input logic v, input logic [31:0] din,
                              input logic rdy, input logic vld, input logic [31:0] dout,
                              input logic sel, input logic [1:0] st, input int cnt);
    vec_t r;
    r.l = l; r.c = c; r.v = v; r.din = din; r.rdy = rdy; r.vld = vld;
    r.dout = dout; r.sel = sel; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic rdy;
    int   n, idx;
    logic [31:0] bp_words[6];

    // x2 bring-up followed by back-to-back payload.
    vecs[0] = mk(1, 1, 0, 0, 0, 0, IDLE, 0, 1, 0);
    for (int i = 1; i <= 8; i++)
      vecs[i] = mk(1, 1, 0, 0, 1, 1, TS, 1'((i - 1) % 2), (i == 8) ? 2'd2 : 2'd1, 0);
    vecs[9]  = mk(1, 1, 1, 32'hAAAAAAAA, 1, 0, IDLE, 0, 2, 1);
    vecs[10] = mk(1, 1, 1, 32'hEEEEEEEE, 1, 1, 32'hAAAAAAAA, 0, 2, 1);
    vecs[11] = mk(1, 1, 1, 32'hCCCCCCCC, 1, 1, 32'hEEEEEEEE, 1, 2, 1);
    vecs[12] = mk(1, 1, 1, 32'h11111111, 1, 1, 32'hCCCCCCCC, 0, 2, 1);
    vecs[13] = mk(1, 1, 0, 0, 1, 1, 32'h11111111, 1, 2, 0);
    vecs[14] = mk(1, 1, 0, 0, 1, 0, IDLE, 0, 2, 0);

    reset = 1'b1; link_en = 0; cfg_x2 = 0; in_valid = 0; in_data = '0;
    model_reset();
    @(negedge clk_2f);
    @(negedge clk_2f);
    check_reset_values("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].l, vecs[i].c, vecs[i].v, vecs[i].din, rdy);
      chk($sformatf("vec%0d_ready", i), rdy, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].vld);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
      if (vecs[i].vld) chk($sformatf("vec%0d_sel", i), out_sel, vecs[i].sel);
      chk($sformatf("vec%0d_state", i), state_o, vecs[i].st);
      chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].cnt);
    end

    // x1 mode; cfg_x2 flipping during DATA must not change lane.
    cycle(0, 0, 0, 0, rdy);
    cycle(1, 0, 0, 0, rdy);
    n = 0;
    for (int i = 0; i < TSN; i++) begin
      cycle(1, 0, 0, 0, rdy);
      if (out_valid && out_data == TS && out_sel == 0) n++;
    end
    chk("x1_ts_words", n, TSN);
    chk("x1_in_data", state_o, 2);
    cycle(1, 1, 1, 32'h99999999, rdy);
    cycle(1, 0, 1, 32'hFFFFFFFF, rdy);
    chk("x1_first_payload", out_data, 32'h99999999);
    cycle(1, 1, 0, 0, rdy);
    chk("x1_second_payload", out_data, 32'hFFFFFFFF);
    chk("x1_second_sel", out_sel, 0);
    cycle(1, 1, 0, 0, rdy);

    // Backpressure: six words offered from the start of x2 training.
    cycle(0, 0, 0, 0, rdy);
    cycle(1, 1, 0, 0, rdy);
    for (int i = 0; i < 6; i++) bp_words[i] = 32'hB0000000 + i;
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() == DEPTH) begin
        cycle(1, 1, idx < 6, (idx < 6) ? bp_words[idx] : '0, rdy);
        chk("bp_full_blocks_ready", rdy, 0);
      end else begin
        cycle(1, 1, idx < 6, (idx < 6) ? bp_words[idx] : '0, rdy);
      end
      if (rdy && idx < 6) idx++;
    end
    chk("bp_all_accepted", idx, 6);
    chk("bp_drained", fifo_count, 0);

    // Link drop with three buffered words, then restart.
    cycle(1, 1, 1, 32'h0000D001, rdy);
    cycle(0, 0, 0, 0, rdy);
    cycle(1, 1, 0, 0, rdy);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 32'hD0000010 + i, rdy);
    chk("drop_pre_count", fifo_count, 3);
    cycle(0, 1, 1, 32'hDEADBEEF, rdy);
    chk("drop_state", state_o, 0);
    chk("drop_count", fifo_count, 0);
    chk("drop_valid", out_valid, 0);
    chk("drop_sel", out_sel, 0);
    cycle(1, 1, 0, 0, rdy);
    n = 0;
    for (int i = 0; i < 2 * TSN; i++) begin
      cycle(1, 1, 0, 0, rdy);
      if (out_valid && out_data == TS) n++;
    end
    chk("restart_ts_words", n, 2 * TSN);
    chk("restart_state", state_o, 2);

    // Asynchronous reset after three x2 training words.
    cycle(0, 0, 0, 0, rdy);
    cycle(1, 1, 0, 0, rdy);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, rdy);
    async_reset("async");
    cycle(1, 1, 0, 0, rdy);
    n = 0;
    for (int i = 0; i < 2 * TSN; i++) begin
      cycle(1, 1, 0, 0, rdy);
      if (out_valid && out_data == TS && out_sel == 1'(i % 2)) n++;
    end
    chk("post_reset_ts_words", n, 2 * TSN);

    // Randomized traffic with occasional link drops and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) async_reset("rand_reset");
      cycle($urandom_range(0, 99) < 97, 1'($urandom), $urandom_range(0, 99) < 60, $urandom, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
